// File: rtl/ppu_sprite_eval_n.sv
`timescale 1ns/1ps
// ppu_sprite_eval_n
// Per-scanline sprite evaluation for a NES-style PPU. The block scans primary OAM
// and copies up to MAX_SLOTS in-range sprites into secondary OAM. After the slots
// are full it runs the overflow search, which can reproduce the hardware's
// diagonal-scan bug. Work advances only on "ticks": even dots of visible lines
// while sprite rendering is enabled.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   x_i, y_i             current dot / scanline
//   spr_enable_i         sprite rendering enabled (0 freezes evaluation)
//   tall_i               1 = 8x16 sprites, 0 = 8x8
//   oam_addr_o           primary OAM read address {n,m}
//   oam_data_i           primary OAM read data (same cycle as oam_addr_o)
//   new_oam_addr_i/_w_i  CPU OAMADDR value and write strobe
//   sec_oam_addr_i       secondary OAM read address
//   sec_oam_data_o       secondary OAM read data (combinational)
//   found_count_o        sprites copied this line
//   overflow_o           sprite overflow flag
//   slot_0_is_spr_0_o    OAM sprite 0 landed in slot 0
//   eval_done_o          evaluation finished for this line
module ppu_sprite_eval_n #(
    parameter int MAX_SLOTS       = 8,
    parameter int NUM_SPRITES     = 64,
    parameter int EMULATE_OVF_BUG = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [8:0]                       x_i,
    input  logic [8:0]                       y_i,
    input  logic                             spr_enable_i,
    input  logic                             tall_i,
    output logic [7:0]                       oam_addr_o,
    input  logic [7:0]                       oam_data_i,
    input  logic [7:0]                       new_oam_addr_i,
    input  logic                             new_oam_addr_w_i,
    input  logic [$clog2(4*MAX_SLOTS)-1:0]   sec_oam_addr_i,
    output logic [7:0]                       sec_oam_data_o,
    output logic [$clog2(MAX_SLOTS+1)-1:0]   found_count_o,
    output logic                             overflow_o,
    output logic                             slot_0_is_spr_0_o,
    output logic                             eval_done_o
);

    localparam int SEC_BYTES = 4 * MAX_SLOTS;
    localparam int SEC_AW    = $clog2(SEC_BYTES);
    // The pointer must be able to reach SEC_BYTES, one past the last byte.
    localparam int PTR_W     = $clog2(SEC_BYTES + 1);
    localparam int CNT_W     = $clog2(MAX_SLOTS + 1);
    localparam int N_W       = $clog2(NUM_SPRITES);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        COPY_Y    = 3'd1,
        COPY_DATA = 3'd2,
        OVF_CHECK = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [1:0]         m_q, m_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               s0_q, s0_d;
    logic               cleared_q, cleared_d;
    logic               sec_we;
    logic               sec_fill;
    logic [7:0]         sec_oam [SEC_BYTES];

    logic               tick;
    logic               advance;
    logic [8:0]         diff;
    logic               hit;
    logic               n_last;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_full;
    logic               ptr_in_range;
    logic [5:0]         n_ext;

    assign tick    = spr_enable_i & ~x_i[0] & (y_i < 9'd240);
    // An OAMADDR write wins over a tick in the same cycle and swallows it.
    assign advance = tick & ~new_oam_addr_w_i;

    // Range test done in 9 bits so that Y+height never wraps past 255.
    assign diff = {1'b0, y_i[7:0]} - {1'b0, oam_data_i};
    assign hit  = ~diff[8] && (diff < (tall_i ? 9'd16 : 9'd8));

    assign n_last       = (n_q == N_W'(NUM_SPRITES - 1));
    assign cnt_inc      = cnt_q + CNT_W'(1);
    assign cnt_full     = (cnt_inc == CNT_W'(MAX_SLOTS));
    assign ptr_in_range = (ptr_q < PTR_W'(SEC_BYTES));

    // Next-state and datapath updates; applied by the registers only on ticks.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        m_d       = m_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        s0_d      = s0_q;
        cleared_d = cleared_q;
        sec_we    = 1'b0;
        sec_fill  = 1'b0;

        case (state_q)
            INIT: begin
                // Only the first INIT tick wipes the line state, so an OAMADDR
                // write later in INIT still chooses the starting sprite.
                if (!cleared_q) begin
                    sec_fill  = 1'b1;
                    n_d       = '0;
                    m_d       = '0;
                    ptr_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    s0_d      = 1'b0;
                    cleared_d = 1'b1;
                end
                if (x_i >= 9'd64) begin
                    state_d = COPY_Y;
                end
            end

            COPY_Y: begin
                // The Y byte is written even on a miss; the next miss or the
                // real copy overwrites it.
                sec_we = ptr_in_range;
                if (hit) begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    m_d     = m_q + 2'd1;
                    state_d = COPY_DATA;
                end else begin
                    n_d = n_q + N_W'(1);
                    if (n_last) begin
                        state_d = DONE;
                    end
                end
            end

            COPY_DATA: begin
                sec_we = ptr_in_range;
                ptr_d  = ptr_q + PTR_W'(1);
                m_d    = m_q + 2'd1;
                if (n_q == '0) begin
                    s0_d = 1'b1;
                end
                if (m_q == 2'd3) begin
                    n_d   = n_q + N_W'(1);
                    cnt_d = cnt_inc;
                    if (n_last) begin
                        state_d = DONE;
                    end else if (cnt_full) begin
                        state_d = OVF_CHECK;
                    end else begin
                        state_d = COPY_Y;
                    end
                end
            end

            OVF_CHECK: begin
                if (hit) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    n_d = n_q + N_W'(1);
                    // The hardware bug also steps the byte index, so later
                    // sprites are tested on their tile/attr/X bytes.
                    m_d = (EMULATE_OVF_BUG != 0) ? (m_q + 2'd1) : 2'd0;
                    if (n_last) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                ptr_d = '0;
                if (x_i == 9'd0) begin
                    state_d   = INIT;
                    cleared_d = 1'b0;
                end
            end

            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DONE;
        end else if (advance) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= '0;
            m_q       <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            s0_q      <= 1'b0;
            cleared_q <= 1'b1;
        end else if (new_oam_addr_w_i) begin
            n_q <= new_oam_addr_i[N_W+1:2];
            m_q <= new_oam_addr_i[1:0];
        end else if (advance) begin
            n_q       <= n_d;
            m_q       <= m_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            s0_q      <= s0_d;
            cleared_q <= cleared_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SEC_BYTES; i++) begin
                sec_oam[i] <= 8'hFF;
            end
        end else if (advance) begin
            if (sec_fill) begin
                for (int i = 0; i < SEC_BYTES; i++) begin
                    sec_oam[i] <= 8'hFF;
                end
            end else if (sec_we) begin
                sec_oam[ptr_q[SEC_AW-1:0]] <= oam_data_i;
            end
        end
    end

    assign n_ext      = 6'(n_q);
    assign oam_addr_o = {n_ext, m_q};

    // Addresses past the populated bytes read back as empty (0xFF).
    assign sec_oam_data_o = ({1'b0, sec_oam_addr_i} < (SEC_AW+1)'(SEC_BYTES)) ?
                            sec_oam[sec_oam_addr_i] : 8'hFF;

    assign found_count_o     = cnt_q;
    assign overflow_o        = ovf_q;
    assign slot_0_is_spr_0_o = s0_q;
    assign eval_done_o       = (state_q == DONE);

endmodule

// File: tb/tb_ppu_sprite_eval_n.sv
`timescale 1ns/1ps
// Testbench for ppu_sprite_eval_n. Two instances share one primary OAM model:
// dut_a has the overflow bug emulated, dut_b does not. Each stimulus line queues
// the hand-computed end-of-line result for both instances. One monitor per
// instance compares that result whenever eval_done_o rises.
module tb_ppu_sprite_eval_n;

    typedef struct packed {
        logic [3:0]      found;
        logic            ovf;
        logic            s0;
        logic [31:0][7:0] sec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] x, y;
    logic       spr_enable, tall;
    logic [7:0] new_oam_addr;
    logic       new_oam_addr_w;

    logic [7:0] oam_addr_a, oam_addr_b, oam_data_a, oam_data_b;
    logic [4:0] sec_addr_a = 5'd0;
    logic [4:0] sec_addr_b = 5'd0;
    logic [7:0] sec_data_a, sec_data_b;
    logic [3:0] found_a, found_b;
    logic       ovf_a, ovf_b, s0_a, s0_b, done_a, done_b;

    logic [7:0] oam [256];

    exp_t exp_q_a[$];
    exp_t exp_q_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   busy_a = 1'b0;
    bit   busy_b = 1'b0;
    bit   boot_done = 1'b0;

    always #5 clk = ~clk;

    assign oam_data_a = oam[oam_addr_a];
    assign oam_data_b = oam[oam_addr_b];

    ppu_sprite_eval_n #(.MAX_SLOTS(8), .NUM_SPRITES(64), .EMULATE_OVF_BUG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .x_i(x), .y_i(y),
        .spr_enable_i(spr_enable), .tall_i(tall),
        .oam_addr_o(oam_addr_a), .oam_data_i(oam_data_a),
        .new_oam_addr_i(new_oam_addr), .new_oam_addr_w_i(new_oam_addr_w),
        .sec_oam_addr_i(sec_addr_a), .sec_oam_data_o(sec_data_a),
        .found_count_o(found_a), .overflow_o(ovf_a),
        .slot_0_is_spr_0_o(s0_a), .eval_done_o(done_a)
    );

    ppu_sprite_eval_n #(.MAX_SLOTS(8), .NUM_SPRITES(64), .EMULATE_OVF_BUG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .x_i(x), .y_i(y),
        .spr_enable_i(spr_enable), .tall_i(tall),
        .oam_addr_o(oam_addr_b), .oam_data_i(oam_data_b),
        .new_oam_addr_i(new_oam_addr), .new_oam_addr_w_i(new_oam_addr_w),
        .sec_oam_addr_i(sec_addr_b), .sec_oam_data_o(sec_data_b),
        .found_count_o(found_b), .overflow_o(ovf_b),
        .slot_0_is_spr_0_o(s0_b), .eval_done_o(done_b)
    );

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // All sprites off-screen (Y=0xF0) except sprite 63 at Y=0xFF; other bytes
    // hold their own OAM address so copied data is recognisable.
    task automatic resetOam();
        for (int i = 0; i < 64; i++) begin
            oam[4*i] = 8'hF0;
            for (int k = 1; k < 4; k++) begin
                oam[4*i+k] = 8'(4*i+k);
            end
        end
        oam[252] = 8'hFF;
    endtask

    function automatic exp_t blankExp();
        exp_t r;
        r.found = 4'd0;
        r.ovf   = 1'b0;
        r.s0    = 1'b0;
        r.sec   = {32{8'hFF}};
        return r;
    endfunction

    function automatic exp_t setSlot(input exp_t e, input int slot, input logic [7:0] yv, input int spr);
        exp_t r;
        r = e;
        r.sec[slot*4] = yv;
        for (int k = 1; k < 4; k++) begin
            r.sec[slot*4+k] = 8'(spr*4+k);
        end
        return r;
    endfunction

    task automatic pushBoth(input exp_t ea, input exp_t eb);
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_q_a.size() == 0 && exp_q_b.size() == 0 && !busy_a && !busy_b) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: pending a=%0d b=%0d, required 0", exp_q_a.size(), exp_q_b.size());
            exp_q_a.delete();
            exp_q_b.delete();
        end
    endtask

    // One scanline, dots 0..340. Optional events: OAMADDR strobe at strobe_x,
    // enable dropped for 100 clocks at freeze_x, reset pulse at reset_x.
    task automatic applyStimulus(input logic [8:0] line_y, input logic line_tall,
                                 input int strobe_x, input logic [7:0] strobe_val,
                                 input int freeze_x, input int freeze_found,
                                 input int reset_x);
        y = line_y;
        tall = line_tall;
        spr_enable = 1'b1;
        for (int xi = 0; xi <= 340; xi++) begin
            @(negedge clk);
            x = 9'(xi);
            new_oam_addr_w = 1'b0;
            if (xi == strobe_x) begin
                new_oam_addr = strobe_val;
                new_oam_addr_w = 1'b1;
            end
            if (strobe_x >= 0 && (xi == strobe_x + 1 || xi == strobe_x + 3)) begin
                checkOutput("oamaddr_a", 256'(oam_addr_a), 256'(strobe_val));
                checkOutput("oamaddr_b", 256'(oam_addr_b), 256'(strobe_val));
            end
            if (xi == freeze_x) begin
                spr_enable = 1'b0;
                repeat (100) @(negedge clk);
                checkOutput("freeze_done_a", 256'(done_a), 256'(0));
                checkOutput("freeze_found_a", 256'(found_a), 256'(freeze_found));
                checkOutput("freeze_found_b", 256'(found_b), 256'(freeze_found));
                spr_enable = 1'b1;
            end
            if (xi == reset_x) begin
                #1 rst_n = 1'b0;
                #1;
                checkOutput("rst_done_a", 256'(done_a), 256'(1));
                checkOutput("rst_found_a", 256'(found_a), 256'(0));
                checkOutput("rst_oamaddr_a", 256'(oam_addr_a), 256'(0));
                checkOutput("rst_oamaddr_b", 256'(oam_addr_b), 256'(0));
                #1 rst_n = 1'b1;
            end
        end
        waitIdle();
    endtask

    initial begin : monitor_a
        exp_t e;
        logic [31:0][7:0] act;
        wait (boot_done);
        forever begin
            busy_a = 1'b1;
            if (exp_q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done_a: eval_done_o rose, no result expected");
            end else begin
                e = exp_q_a.pop_front();
                for (int i = 0; i < 32; i++) begin
                    sec_addr_a = 5'(i);
                    #1;
                    act[i] = sec_data_a;
                end
                checkOutput("found_a", 256'(found_a), 256'(e.found));
                checkOutput("ovf_a", 256'(ovf_a), 256'(e.ovf));
                checkOutput("s0_a", 256'(s0_a), 256'(e.s0));
                checkOutput("secoam_a", act, e.sec);
            end
            busy_a = 1'b0;
            @(posedge done_a);
            #2;
        end
    end

    initial begin : monitor_b
        exp_t e;
        logic [31:0][7:0] act;
        wait (boot_done);
        forever begin
            busy_b = 1'b1;
            if (exp_q_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done_b: eval_done_o rose, no result expected");
            end else begin
                e = exp_q_b.pop_front();
                for (int i = 0; i < 32; i++) begin
                    sec_addr_b = 5'(i);
                    #1;
                    act[i] = sec_data_b;
                end
                checkOutput("found_b", 256'(found_b), 256'(e.found));
                checkOutput("ovf_b", 256'(ovf_b), 256'(e.ovf));
                checkOutput("s0_b", 256'(s0_b), 256'(e.s0));
                checkOutput("secoam_b", act, e.sec);
            end
            busy_b = 1'b0;
            @(posedge done_b);
            #2;
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        exp_t e, eb;

        rst_n = 1'b0;
        x = 9'd0;
        y = 9'd0;
        spr_enable = 1'b0;
        tall = 1'b0;
        new_oam_addr = 8'd0;
        new_oam_addr_w = 1'b0;
        resetOam();

        // Reset state.
        pushBoth(blankExp(), blankExp());
        repeat (3) @(negedge clk);
        checkOutput("boot_oamaddr_a", 256'(oam_addr_a), 256'(0));
        checkOutput("boot_done_a", 256'(done_a), 256'(1));
        checkOutput("boot_done_b", 256'(done_b), 256'(1));
        rst_n = 1'b1;
        @(negedge clk);
        boot_done = 1'b1;
        waitIdle();

        // Sprite 0 at Y=15 on line 20: one 8x8 sprite, slot 0.
        resetOam();
        oam[0] = 8'd15;
        e = setSlot(blankExp(), 0, 8'd15, 0);
        e.found = 4'd1;
        e.s0 = 1'b1;
        pushBoth(e, e);
        applyStimulus(9'd20, 1'b0, -1, 8'h00, -1, 0, -1);

        // Sprite 5 at Y=8, d=12: visible only as 8x16.
        resetOam();
        oam[20] = 8'd8;
        e = setSlot(blankExp(), 0, 8'd8, 5);
        e.found = 4'd1;
        pushBoth(e, e);
        applyStimulus(9'd20, 1'b1, -1, 8'h00, -1, 0, -1);

        // Same as 8x8: nothing copied; the last miss (sprite 63, Y=0xF0) leaves
        // its Y in byte 0.
        oam[252] = 8'hF0;
        e = blankExp();
        e.sec[0] = 8'hF0;
        pushBoth(e, e);
        applyStimulus(9'd20, 1'b0, -1, 8'h00, -1, 0, -1);

        // Height boundaries on line 27: d=7 hits, d=8 misses, d=15 misses in 8x8.
        resetOam();
        oam[12] = 8'd20;
        oam[16] = 8'd19;
        oam[24] = 8'd12;
        e = setSlot(blankExp(), 0, 8'd20, 3);
        e.found = 4'd1;
        pushBoth(e, e);
        applyStimulus(9'd27, 1'b0, -1, 8'h00, -1, 0, -1);

        // Ten sprites on line 50: eight copied, sprite 8 flags overflow.
        resetOam();
        for (int i = 0; i < 10; i++) oam[4*i] = 8'd50;
        e = blankExp();
        for (int i = 0; i < 8; i++) e = setSlot(e, i, 8'd50, i);
        e.found = 4'd8;
        e.s0 = 1'b1;
        e.ovf = 1'b1;
        pushBoth(e, e);
        applyStimulus(9'd50, 1'b0, -1, 8'h00, -1, 0, -1);

        // Eight sprites, sprite 9 byte 1 = 50: only the diagonal scan sees it.
        resetOam();
        for (int i = 0; i < 8; i++) oam[4*i] = 8'd50;
        oam[37] = 8'd50;
        e = blankExp();
        for (int i = 0; i < 8; i++) e = setSlot(e, i, 8'd50, i);
        e.found = 4'd8;
        e.s0 = 1'b1;
        eb = e;
        e.ovf = 1'b1;
        eb.ovf = 1'b0;
        pushBoth(e, eb);
        applyStimulus(9'd50, 1'b0, -1, 8'h00, -1, 0, -1);

        // OAMADDR=0x08 during INIT: scan starts at sprite 2, sprite 0 skipped.
        resetOam();
        oam[0] = 8'd30;
        oam[8] = 8'd25;
        e = setSlot(blankExp(), 0, 8'd25, 2);
        e.found = 4'd1;
        pushBoth(e, e);
        applyStimulus(9'd30, 1'b0, 10, 8'h08, -1, 0, -1);

        // Y=0xFF on line 0 must not wrap into range.
        resetOam();
        pushBoth(blankExp(), blankExp());
        applyStimulus(9'd0, 1'b0, -1, 8'h00, -1, 0, -1);

        // Enable dropped mid-line after sprite 0 was copied; resumes unchanged.
        resetOam();
        oam[0] = 8'd15;
        e = setSlot(blankExp(), 0, 8'd15, 0);
        e.found = 4'd1;
        e.s0 = 1'b1;
        pushBoth(e, e);
        applyStimulus(9'd20, 1'b0, -1, 8'h00, 80, 1, -1);

        // Reset in mid-evaluation returns straight to the reset state.
        pushBoth(blankExp(), blankExp());
        applyStimulus(9'd20, 1'b0, -1, 8'h00, -1, 0, 100);

        // Normal line after the reset.
        pushBoth(e, e);
        applyStimulus(9'd20, 1'b0, -1, 8'h00, -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
